// File: rtl/w5300_pkg.sv
// Shared constants for the W5300 transmit path: FSM encoding, error codes
// and the round-robin pointer helper.
package w5300_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARB   = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_BUSY  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [2:0] ERR_NONE      = 3'b000;
  localparam logic [2:0] ERR_ZERO_SIZE = 3'b110;
  localparam logic [2:0] ERR_TIMEOUT   = 3'b111;

  // Index following idx in a ring of n slots.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/w5300_tx_arbiter_rr_picker.sv
// Combinational round-robin selector: first set request at or after the
// pointer, wrapping, returned as one-hot plus binary index.
module rr_picker
  import w5300_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] rr_ptr_i,
  output logic [N-1:0]  winner_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  // Scanning from the farthest offset down lets the nearest hit win last.
  always_comb begin
    int j;
    j        = 0;
    winner_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(rr_ptr_i) + k;
      if (j >= N) j = j - N;
      if (req_i[j]) begin
        winner_o    = '0;
        winner_o[j] = 1'b1;
        idx_o       = j[IW-1:0];
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/w5300_tx_arbiter.sv
// Round-robin arbiter sharing the single w5300_entry transmit channel among
// NUM_REQ requesters. Optional watchdog: define W5300_TX_ARB_TIMEOUT_EN.
module w5300_tx_arbiter
  import w5300_pkg::*;
#(
  parameter int NUM_REQ              = 4,
  parameter int DATA_WIDTH           = 16,
  parameter int TX_BUFFER_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES       = 1_000_000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ*32-1:0]             req_ip,
  input  logic [NUM_REQ*16-1:0]             req_port,
  input  logic [NUM_REQ*32-1:0]             req_size,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
  output logic [NUM_REQ-1:0]                grant,
  output logic [TX_BUFFER_ADDR_WIDTH-1:0]   buf_addr,
  output logic [NUM_REQ-1:0]                done,
  output logic                              err,
  output logic [2:0]                        err_code_o,
  output logic                              tx_req,
  output logic [31:0]                       dest_ip,
  output logic [15:0]                       dest_port,
  output logic [31:0]                       tx_data_size,
  output logic [DATA_WIDTH-1:0]             tx_data,
  input  logic [TX_BUFFER_ADDR_WIDTH-1:0]   tx_buffer_addr,
  input  logic                              busy_n,
  input  logic [2:0]                        err_code
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("w5300_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  logic [2:0]         state_q, state_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               err_q, err_d;
  logic [2:0]         code_q, code_d;
  logic               tx_req_q, tx_req_d;
  logic [31:0]        ip_q, ip_d;
  logic [15:0]        port_q, port_d;
  logic [31:0]        size_q, size_d;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IW-1:0]      pick_idx;
  logic               pick_valid;
  logic               timeout_hit;

  rr_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_picker (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .winner_o (pick_onehot),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

`ifdef W5300_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Restarts on every state change, so ISSUE and BUSY each get a full budget.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign timeout_hit = ((state_q == ST_ISSUE) || (state_q == ST_BUSY)) &&
                       (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    int sel;
    sel      = int'(pick_idx);
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
    done_d   = '0;
    err_d    = 1'b0;
    code_d   = ERR_NONE;
    tx_req_d = tx_req_q;
    ip_d     = ip_q;
    port_d   = port_q;
    size_d   = size_q;

    case (state_q)
      ST_IDLE: begin
        grant_d  = '0;
        tx_req_d = 1'b0;
        if (|req) state_d = ST_ARB;
      end

      ST_ARB: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          grant_d = pick_onehot;
          ip_d    = req_ip[sel*32 +: 32];
          port_d  = req_port[sel*16 +: 16];
          size_d  = req_size[sel*32 +: 32];
          if (req_size[sel*32 +: 32] == 32'd0) begin
            state_d = ST_DONE;
            done_d  = pick_onehot;
            err_d   = 1'b1;
            code_d  = ERR_ZERO_SIZE;
          end else begin
            state_d  = ST_ISSUE;
            tx_req_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        if (!busy_n) begin
          tx_req_d = 1'b0;
          state_d  = ST_BUSY;
        end else if (timeout_hit) begin
          tx_req_d = 1'b0;
          state_d  = ST_DONE;
          done_d   = grant_q;
          err_d    = 1'b1;
          code_d   = ERR_TIMEOUT;
        end
      end

      ST_BUSY: begin
        if (busy_n) begin
          state_d = ST_DONE;
          done_d  = grant_q;
          err_d   = (err_code != ERR_NONE);
          code_d  = err_code;
        end else if (timeout_hit) begin
          state_d = ST_DONE;
          done_d  = grant_q;
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
        end
      end

      ST_DONE: begin
        grant_d  = '0;
        tx_req_d = 1'b0;
        rr_ptr_d = IW'(rr_next(int'(owner_q), NUM_REQ));
        state_d  = ST_IDLE;
      end

      default: begin
        grant_d  = '0;
        tx_req_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
      tx_req_q <= 1'b0;
      ip_q     <= '0;
      port_q   <= '0;
      size_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      err_q    <= err_d;
      code_q   <= code_d;
      tx_req_q <= tx_req_d;
      ip_q     <= ip_d;
      port_q   <= port_d;
      size_q   <= size_d;
    end
  end

  // Buffer data follows the owner combinationally so the entry sees it on the
  // same cycle it drives tx_buffer_addr.
  always_comb begin
    int o;
    o       = int'(owner_q);
    tx_data = '0;
    if (|grant_q) tx_data = req_data[o*DATA_WIDTH +: DATA_WIDTH];
  end

  assign buf_addr     = tx_buffer_addr;
  assign grant        = grant_q;
  assign done         = done_q;
  assign err          = err_q;
  assign err_code_o   = code_q;
  assign tx_req       = tx_req_q;
  assign dest_ip      = ip_q;
  assign dest_port    = port_q;
  assign tx_data_size = size_q;

endmodule

// File: tb/tb_w5300_tx_arbiter.sv
// Directed self-checking bench for w5300_tx_arbiter with a simple entry model.
// Define W5300_TX_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_w5300_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int AW = 12;
`ifdef W5300_TX_ARB_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 1_000_000;
`endif

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*32-1:0]  req_ip;
  logic [NR*16-1:0]  req_port;
  logic [NR*32-1:0]  req_size;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     grant;
  logic [AW-1:0]     buf_addr;
  logic [NR-1:0]     done;
  logic              err;
  logic [2:0]        err_code_o;
  logic              tx_req;
  logic [31:0]       dest_ip;
  logic [15:0]       dest_port;
  logic [31:0]       tx_data_size;
  logic [DW-1:0]     tx_data;
  logic [AW-1:0]     tx_buffer_addr;
  logic              busy_n;
  logic [2:0]        err_code;

  w5300_tx_arbiter #(
    .NUM_REQ              (NR),
    .DATA_WIDTH           (DW),
    .TX_BUFFER_ADDR_WIDTH (AW),
    .TIMEOUT_CYCLES       (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .req_ip         (req_ip),
    .req_port       (req_port),
    .req_size       (req_size),
    .req_data       (req_data),
    .grant          (grant),
    .buf_addr       (buf_addr),
    .done           (done),
    .err            (err),
    .err_code_o     (err_code_o),
    .tx_req         (tx_req),
    .dest_ip        (dest_ip),
    .dest_port      (dest_port),
    .tx_data_size   (tx_data_size),
    .tx_data        (tx_data),
    .tx_buffer_addr (tx_buffer_addr),
    .busy_n         (busy_n),
    .err_code       (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Event monitor, sampled mid-cycle away from the active edge.
  int             txreq_rises = 0;
  int             txreq_rise_cyc = 0;
  int             busy_rise_cyc = 0;
  int             done_count = 0;
  int             done_cyc = 0;
  logic [NR-1:0]  last_done = '0;
  logic           last_err = 1'b0;
  logic [2:0]     last_code = 3'b000;
  logic           txreq_prev = 1'b0;
  logic           busy_prev = 1'b1;
  logic [NR-1:0]  grant_prev = '0;
  logic [NR-1:0]  grant_log[$];

  always @(negedge clk) begin
    if (tx_req && !txreq_prev) begin
      txreq_rises++;
      txreq_rise_cyc = cyc;
    end
    txreq_prev = tx_req;
    if (busy_n && !busy_prev) busy_rise_cyc = cyc;
    busy_prev = busy_n;
    if (done != '0) begin
      done_count++;
      done_cyc  = cyc;
      last_done = done;
      last_err  = err;
      last_code = err_code_o;
    end
    if (grant != '0 && grant_prev == '0) grant_log.push_back(grant);
    grant_prev = grant;
  end

  // Entry model: on tx_req, drop busy_n two cycles later, hold it low for
  // busyLen cycles, then release it with retCode on err_code.
  bit       modelEn = 1'b1;
  int       busyLen = 50;
  logic [2:0] retCode = 3'b000;

  initial begin
    busy_n   = 1'b1;
    err_code = 3'b000;
    forever begin
      @(posedge clk);
      #1;
      if (modelEn && tx_req) begin
        repeat (2) @(posedge clk);
        #1 busy_n = 1'b0;
        repeat (busyLen) @(posedge clk);
        #1;
        err_code = retCode;
        busy_n   = 1'b1;
        @(posedge clk);
        #1 err_code = 3'b000;
      end
    end
  end

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got time %0t, expected < 500000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NR-1:0] r);
    req = r;
  endtask

  task automatic setSlot(input int i, input logic [31:0] ip, input logic [15:0] port,
                         input logic [31:0] size, input logic [DW-1:0] data);
    req_ip[i*32 +: 32]   = ip;
    req_port[i*16 +: 16] = port;
    req_size[i*32 +: 32] = size;
    req_data[i*DW +: DW] = data;
  endtask

  task automatic waitDone(input int maxc, input string tag);
    int  start;
    bit  seen;
    start = done_count;
    seen  = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      tick();
      if (done_count > start) seen = 1'b1;
    end
    checkOutput(tag, 64'(seen), 64'd1);
  endtask

  initial begin
    logic [NR-1:0] expOrder[5];
    int  base;
    bit  seen;

    expOrder[0] = 4'b0001; expOrder[1] = 4'b0010; expOrder[2] = 4'b0100;
    expOrder[3] = 4'b1000; expOrder[4] = 4'b0001;

    rst = 1'b1;
    req = '0;
    req_ip = '0;
    req_port = '0;
    req_size = '0;
    req_data = '0;
    tx_buffer_addr = 12'h123;
    for (int i = 0; i < NR; i++)
      setSlot(i, 32'h0A000001 + 32'(i), 16'(1000 + i), 32'(10 * (i + 1)), 16'(16'h1110 * (i + 1)));
    repeat (3) tick();

    $display("[TB] reset state");
    checkOutput("rst_grant", 64'(grant), 64'd0);
    checkOutput("rst_tx_req", 64'(tx_req), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    checkOutput("rst_dest_ip", 64'(dest_ip), 64'd0);
    checkOutput("rst_tx_data", 64'(tx_data), 64'd0);
    checkOutput("buf_addr_passthru", 64'(buf_addr), 64'h123);
    rst = 1'b0;
    tick();

    $display("[TB] single request");
    setSlot(0, 32'hC0A86F01, 16'd7000, 32'd16, 16'hA5A5);
    busyLen = 50;
    base = txreq_rises;
    applyStimulus(4'b0001);
    tick();
    tick();
    checkOutput("t1_grant", 64'(grant), 64'b0001);
    checkOutput("t1_tx_req", 64'(tx_req), 64'd1);
    checkOutput("t1_dest_ip", 64'(dest_ip), 64'hC0A86F01);
    checkOutput("t1_dest_port", 64'(dest_port), 64'd7000);
    checkOutput("t1_size", 64'(tx_data_size), 64'd16);
    checkOutput("t1_tx_data", 64'(tx_data), 64'hA5A5);
    waitDone(100, "t1_done_seen");
    checkOutput("t1_done_vec", 64'(last_done), 64'b0001);
    checkOutput("t1_err", 64'(last_err), 64'd0);
    checkOutput("t1_done_latency", 64'(done_cyc - busy_rise_cyc), 64'd1);
    checkOutput("t1_txreq_phases", 64'(txreq_rises - base), 64'd1);
    applyStimulus(4'b0000);
    repeat (3) tick();
    checkOutput("t1_idle_grant", 64'(grant), 64'd0);
    checkOutput("t1_idle_tx_data", 64'(tx_data), 64'd0);

    $display("[TB] four requesters from reset");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NR; i++)
      setSlot(i, 32'h0A000001 + 32'(i), 16'(1000 + i), 32'(10 * (i + 1)), 16'(16'h1110 * (i + 1)));
    busyLen = 3;
    grant_log.delete();
    applyStimulus(4'b1111);
    for (int n = 0; n < 5; n++) waitDone(40, "t2_done_seen");
    applyStimulus(4'b0000);
    checkOutput("t2_grant_count", 64'(grant_log.size()), 64'd5);
    for (int n = 0; n < 5; n++)
      checkOutput($sformatf("t2_order_%0d", n), 64'(grant_log.size() > n ? grant_log[n] : 4'b0000), 64'(expOrder[n]));
    repeat (3) tick();

    $display("[TB] zero size");
    setSlot(2, 32'h0A000003, 16'd1002, 32'd0, 16'h3333);
    base = txreq_rises;
    applyStimulus(4'b0100);
    tick();
    tick();
    checkOutput("t3_done", 64'(done), 64'b0100);
    checkOutput("t3_err", 64'(err), 64'd1);
    checkOutput("t3_code", 64'(err_code_o), 64'd6);
    checkOutput("t3_grant", 64'(grant), 64'b0100);
    applyStimulus(4'b0000);
    repeat (4) tick();
    checkOutput("t3_no_tx_req", 64'(txreq_rises - base), 64'd0);

    $display("[TB] entry error");
    retCode = 3'b010;
    busyLen = 5;
    setSlot(1, 32'h0A000002, 16'd1001, 32'd64, 16'h2222);
    applyStimulus(4'b0010);
    waitDone(40, "t4_done_seen");
    checkOutput("t4_done_vec", 64'(last_done), 64'b0010);
    checkOutput("t4_err", 64'(last_err), 64'd1);
    checkOutput("t4_code", 64'(last_code), 64'd2);
    applyStimulus(4'b0000);
    retCode = 3'b000;
    repeat (3) tick();

    $display("[TB] reset mid-transfer");
    busyLen = 20;
    setSlot(0, 32'h0A000001, 16'd1000, 32'd10, 16'h1111);
    setSlot(3, 32'h0A000004, 16'd1003, 32'd100, 16'h4444);
    applyStimulus(4'b1000);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (grant == 4'b1000 && !tx_req && !busy_n) seen = 1'b1;
    end
    checkOutput("t5_reached_busy", 64'(seen), 64'd1);
    base = done_count;
    rst = 1'b1;
    tick();
    checkOutput("t5_grant", 64'(grant), 64'd0);
    checkOutput("t5_tx_req", 64'(tx_req), 64'd0);
    checkOutput("t5_done", 64'(done), 64'd0);
    rst = 1'b0;
    applyStimulus(4'b0000);
    repeat (25) tick();
    checkOutput("t5_no_done", 64'(done_count - base), 64'd0);
    busyLen = 4;
    applyStimulus(4'b1001);
    tick();
    tick();
    checkOutput("t5_regrant", 64'(grant), 64'b0001);
    waitDone(30, "t5_done_seen");
    applyStimulus(4'b0000);
    repeat (3) tick();

`ifdef W5300_TX_ARB_TIMEOUT_EN
    $display("[TB] timeout");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    modelEn = 1'b0;
    setSlot(0, 32'h0A000001, 16'd1000, 32'd8, 16'h1111);
    applyStimulus(4'b0001);
    waitDone(150, "t6_done_seen");
    checkOutput("t6_latency", 64'(done_cyc - txreq_rise_cyc), 64'd100);
    checkOutput("t6_err", 64'(last_err), 64'd1);
    checkOutput("t6_code", 64'(last_code), 64'd7);
    checkOutput("t6_tx_req", 64'(tx_req), 64'd0);
    applyStimulus(4'b0011);
    repeat (3) tick();
    checkOutput("t6_next_grant", 64'(grant), 64'b0010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(4'b0000);
    modelEn = 1'b1;
    repeat (2) tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/w5300_tx_arbiter.md
# w5300_tx_arbiter

- Shares the single transmit channel of `w5300_entry` among `NUM_REQ` independent requesters.
- Grants the channel round-robin and holds the winning requester's destination, size and buffer data on the entry inputs.
- Sequences `tx_req` against the entry's `busy_n` and reports completion or error per requester.
- Sits between the application-side packet producers and `w5300_entry`, in the `wclk0` (100 MHz) domain.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 16: width of the tx buffer data word.
- `TX_BUFFER_ADDR_WIDTH`, 12: must equal the entry's parameter of the same name.
- `TIMEOUT_CYCLES`, 1_000_000: watchdog limit per phase; used only with the timeout feature.
- `clk  in  1`: system clock (`wclk0`).
- `rst  in  1`: synchronous, active-high reset.
- `req  in  NUM_REQ`: per-requester transmit request, level.
- `req_ip  in  NUM_REQ*32`: destination IPv4 address; slot i at [32i+31:32i].
- `req_port  in  NUM_REQ*16`: destination port.
- `req_size  in  NUM_REQ*32`: payload size in bytes.
- `req_data  in  NUM_REQ*DATA_WIDTH`: buffer read data from each requester.
- `grant  out  NUM_REQ`: one-hot owner of the channel.
- `buf_addr  out  TX_BUFFER_ADDR_WIDTH`: buffer address, fanned out to all requesters.
- `done  out  NUM_REQ`: one-cycle completion pulse for the owner.
- `err  out  1`: qualifies `done`; 1 = transfer failed.
- `err_code_o  out  3`: error code, valid with `done`.
- `tx_req  out  1`: to the entry.
- `dest_ip  out  32`: to the entry.
- `dest_port  out  16`: to the entry.
- `tx_data_size  out  32`: to the entry.
- `tx_data  out  DATA_WIDTH`: to the entry.
- `tx_buffer_addr  in  TX_BUFFER_ADDR_WIDTH`: from the entry.
- `busy_n  in  1`: from the entry.
- `err_code  in  3`: from the entry.

## Operation
- **IDLE:**
  - `grant`=0 and `tx_req`=0.
  - If any `req` is set, go to ARB.
- **ARB**, one cycle:
  - Pick the first set `req` at or after `rr_ptr`, wrapping.
  - Register the owner's `ip/port/size` into holding registers; the outputs are driven from these registers.
  - Set `grant`.
  - `req_size==0` → DONE with `err`=1, code 3'b110, entry never started.
  - Otherwise → ISSUE.
- **ISSUE:**
  - Assert `tx_req`.
  - When `busy_n`=0, deassert `tx_req` and go to BUSY.
- **BUSY:**
  - Stay while `busy_n`=0.
  - On `busy_n`=1, capture `err_code` and go to DONE.
- **DONE**, one cycle:
  - Pulse `done[owner]`.
  - Drive `err` = (code≠0) and `err_code_o` = code.
  - Set `rr_ptr` = owner+1 mod `NUM_REQ`.
  - Clear `grant` and return to IDLE.
- **Muxing:**
  - `tx_data` = `req_data` slice of the owner; 0 when there is no grant.
  - `buf_addr` = `tx_buffer_addr`, unconditionally.
- **Requester contract:**
  - Hold `req` and the parameters stable until `done`.
  - Dropping `req` after grant does not abort; the transfer completes and `done` still pulses.
  - Parameters are sampled only in ARB.
- A requester re-asserting `req` immediately after its `done` competes normally, but it has lowest priority because of `rr_ptr`.
- **Reset:**
  - All outputs 0; `rr_ptr`=0; state IDLE.
  - Reset mid-transfer drops `tx_req` and `grant` in the following cycle without any `done`.
  - The entry is reset by the same `rst`.

## Timing
- `req` rising in IDLE → `grant` after 2 cycles (IDLE→ARB→ISSUE registered), with `tx_req` in the same cycle as `grant`.
- `busy_n` falling → `tx_req` low on the next edge.
- `busy_n` rising → `done` 1 cycle later.
- Minimum spacing between two grants: 3 cycles (DONE, IDLE, ARB).
- All outputs are registered except `tx_data` and `buf_addr`, which are combinational muxes.

## Configuration
- Macro: `W5300_TX_ARB_TIMEOUT_EN`.
- **Defined:**
  - A cycle counter runs in ISSUE and BUSY and clears on each state entry.
  - Reaching `TIMEOUT_CYCLES` forces DONE with `err`=1, code 3'b111.
  - `tx_req` is dropped, and `rr_ptr` advances past the owner.
- **Undefined:** no counter exists; ISSUE and BUSY wait indefinitely.

## Structure
- Shared package `w5300_pkg`:
  - State encoding: IDLE, ARB, ISSUE, BUSY, DONE.
  - Error constants: `ERR_NONE`=3'b000, `ERR_ZERO_SIZE`=3'b110, `ERR_TIMEOUT`=3'b111.
- One sub-module `rr_picker`:
  - Combinational round-robin priority selector.
  - Inputs: `req` and `rr_ptr`. Outputs: one-hot winner and its index.

## Test plan
- **Single request:** `req[0]`=1, ip 192.168.111.1, port 7000, size 16; the entry model holds `busy_n` low for 50 cycles.
  - Expect `grant`=0001, a single `tx_req` high phase, `dest_port`=7000, `tx_data_size`=16.
  - Expect `done[0]` 1 cycle after `busy_n` rises, with `err`=0.
- **All four requesting continuously from reset:** grant order 0,1,2,3,0; no requester is granted twice before all others are served.
- **Zero size:** `req[2]` with size 0 → `done[2]` with `err`=1, code 6; `tx_req` never asserts.
- **Entry error:** the entry model returns `err_code`=3'b010 at completion → `done` with `err`=1, `err_code_o`=2.
- **Reset mid-transfer:** assert `rst` during BUSY → next cycle `grant`=0, `tx_req`=0, no `done`; the next request is granted to requester 0.
- **Timeout (macro defined, `TIMEOUT_CYCLES`=100):** the entry model never lowers `busy_n` → `done` 100 cycles after `tx_req` rises, with `err`=1, code 7.
